// File: rtl/wb_pkg.sv
// Shared encodings for the writeback stage: result sources, load funct3
// codes and the W-slot state machine states.
package wb_pkg;

  // Result source selector values as they arrive on ResultSrcM.
  typedef enum logic [1:0] {
    SRC_ALU  = 2'd0,
    SRC_LOAD = 2'd1,
    SRC_PC4  = 2'd2,
    SRC_CSR  = 2'd3
  } result_src_e;

  // RISC-V load funct3 encodings understood by the extractor.
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Occupancy of the W slot.
  //   EMPTY   : nothing live
  //   READY   : result available, may write/retire
  //   WAIT_LD : live load waiting for its response
  //   DRAIN   : killed load whose response must still be swallowed
  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    READY   = 2'd1,
    WAIT_LD = 2'd2,
    DRAIN   = 2'd3
  } wb_state_e;

endpackage

// File: rtl/wb_load_extract.sv
// Load data extractor: picks the addressed byte or halfword out of the
// aligned memory word and sign- or zero-extends it to XLEN.
module wb_load_extract
  import wb_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] data,
  input  logic [2:0]      funct3,
  input  logic [1:0]      offset,
  output logic [XLEN-1:0] value
);

  logic [31:0] word_v;
  logic [15:0] half_v;
  logic [7:0]  byte_v;

  // Lane selection from the low word, then extension chosen by funct3.
  always_comb begin
    // NOTE: every output of a combinational block gets a value on every
    // path (defaults first or a full case with default); a missed path
    // would infer a latch.
    word_v = data[31:0];
    byte_v = word_v[{offset, 3'b000} +: 8];
    half_v = offset[1] ? word_v[31:16] : word_v[15:0];
    case (funct3)
      F3_LB:   value = XLEN'($signed(byte_v));
      F3_LH:   value = XLEN'($signed(half_v));
      F3_LW:   value = XLEN'($signed(word_v));
      F3_LBU:  value = XLEN'(byte_v);
      F3_LHU:  value = XLEN'(half_v);
      default: value = '0;
    endcase
  end

endmodule

// File: rtl/writeback_stage_pipe.sv
// Writeback stage: owns the MEM/WB register, waits for variable-latency
// load responses, selects the result source and drives the register-file
// write port, forwarding value and retire pulse.
module writeback_stage_pipe
  import wb_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int REG_AW  = 5,
  parameter int NUM_SRC = 4,
  parameter int SRC_W   = $clog2(NUM_SRC)
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              ValidM,
  input  logic              RegWriteM,
  input  logic [SRC_W-1:0]  ResultSrcM,
  input  logic [2:0]        LoadFuncM,
  input  logic [REG_AW-1:0] RdM,
  input  logic [XLEN-1:0]   ALUResultM,
  input  logic [XLEN-1:0]   PCPlus4M,
  input  logic [XLEN-1:0]   CSRDataM,
  input  logic              RspValid,
  input  logic [XLEN-1:0]   RspData,
  input  logic              StallW,
  input  logic              FlushW,
  output logic              ValidW,
  output logic              RegWriteW,
  output logic [REG_AW-1:0] RdW,
  output logic [XLEN-1:0]   ResultW,
  output logic              WaitLoadW,
  output logic              RetireW
);

  // W-slot state
  wb_state_e state_q, state_d;

  // MEM/WB pipeline register
  logic              valid_q,    valid_d;
  logic              regwrite_q, regwrite_d;
  logic [SRC_W-1:0]  src_q,      src_d;
  logic [2:0]        funct3_q,   funct3_d;
  logic [REG_AW-1:0] rd_q,       rd_d;
  logic [XLEN-1:0]   alu_q,      alu_d;
  logic [XLEN-1:0]   pc4_q,      pc4_d;
  logic [XLEN-1:0]   csr_q,      csr_d;
  logic [XLEN-1:0]   ld_data_q,  ld_data_d;

  // Decoded control
  logic            load_busy;
  logic            in_ready;
  logic            capture;
  logic            is_load_m;
  logic            ld_accept;
  logic [XLEN-1:0] ld_value;
  logic [XLEN-1:0] result_mux;

  // Control decode: when the register may load, and whether a response is taken.
  always_comb begin
    load_busy = (state_q == WAIT_LD) || (state_q == DRAIN);
    in_ready  = (state_q == READY);
    // Upstream holds while a load is outstanding, so capture is blocked then.
    capture   = ~StallW & ~load_busy;
    is_load_m = (int'(ResultSrcM) == int'(SRC_LOAD));
    // Only a load already sitting in W accepts data; the capture cycle never does.
    ld_accept = (state_q == WAIT_LD) & RspValid;
  end

  // Next-state logic of the W-slot FSM; flush outranks stall.
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY, READY: begin
        if (FlushW) begin
          state_d = EMPTY;
        end else if (capture) begin
          if (!ValidM)        state_d = EMPTY;
          else if (is_load_m) state_d = WAIT_LD;
          else                state_d = READY;
        end
      end
      WAIT_LD: begin
        // A response arriving together with the flush settles the load at once.
        if (FlushW)        state_d = RspValid ? EMPTY : DRAIN;
        else if (RspValid) state_d = READY;
      end
      DRAIN: begin
        if (RspValid) state_d = EMPTY;
      end
      default: state_d = EMPTY;
    endcase
  end

  // Pipeline register next values: capture from M, kill on flush, latch load data.
  always_comb begin
    valid_d    = valid_q;
    regwrite_d = regwrite_q;
    src_d      = src_q;
    funct3_d   = funct3_q;
    rd_d       = rd_q;
    alu_d      = alu_q;
    pc4_d      = pc4_q;
    csr_d      = csr_q;
    ld_data_d  = ld_data_q;
    if (capture) begin
      valid_d    = ValidM & ~FlushW;
      regwrite_d = RegWriteM;
      src_d      = ResultSrcM;
      funct3_d   = LoadFuncM;
      rd_d       = RdM;
      alu_d      = ALUResultM;
      pc4_d      = PCPlus4M;
      csr_d      = CSRDataM;
    end else if (FlushW) begin
      valid_d = 1'b0;
    end
    if (ld_accept) begin
      ld_data_d = RspData;
    end
  end

  // State and pipeline register, cleared asynchronously.
  always_ff @(posedge CLK or negedge RESET) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values; every register here is a plain flop and
    // is cleared so an abandoned load leaves nothing behind.
    if (!RESET) begin
      state_q    <= EMPTY;
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
      src_q      <= '0;
      funct3_q   <= '0;
      rd_q       <= '0;
      alu_q      <= '0;
      pc4_q      <= '0;
      csr_q      <= '0;
      ld_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      regwrite_q <= regwrite_d;
      src_q      <= src_d;
      funct3_q   <= funct3_d;
      rd_q       <= rd_d;
      alu_q      <= alu_d;
      pc4_q      <= pc4_d;
      csr_q      <= csr_d;
      ld_data_q  <= ld_data_d;
    end
  end

  // Byte/half/word extraction of the latched response; offset is the load address.
  wb_load_extract #(
    .XLEN (XLEN)
  ) u_load_extract (
    .data   (ld_data_q),
    .funct3 (funct3_q),
    .offset (alu_q[1:0]),
    .value  (ld_value)
  );

  // Result source mux; an index beyond the configured sources reads as zero.
  always_comb begin
    result_mux = '0;
    if (int'(src_q) < NUM_SRC) begin
      case (int'(src_q))
        int'(SRC_ALU):  result_mux = alu_q;
        int'(SRC_LOAD): result_mux = ld_value;
        int'(SRC_PC4):  result_mux = pc4_q;
        int'(SRC_CSR):  result_mux = csr_q;
        default:        result_mux = '0;
      endcase
    end
  end

  // Outputs: writes, forwarding and retire are only meaningful in READY.
  always_comb begin
    ValidW    = valid_q;
    RdW       = rd_q;
    // x0 writes are suppressed but the instruction still retires.
    RegWriteW = in_ready & regwrite_q & (rd_q != '0);
    ResultW   = in_ready ? result_mux : '0;
    WaitLoadW = load_busy;
    // A stalled READY instruction repeats its write but retires only on leaving.
    RetireW   = in_ready & ~StallW & ~FlushW;
  end

endmodule

// File: tb/tb_writeback_stage_pipe.sv
// Bench for writeback_stage_pipe: directed scenarios with literal
// expectations plus a randomized run checked every cycle against a
// behavioural model of the W slot.
module tb_writeback_stage_pipe;

  logic        CLK;
  logic        RESET;
  logic        ValidM;
  logic        RegWriteM;
  logic [1:0]  ResultSrcM;
  logic [2:0]  LoadFuncM;
  logic [4:0]  RdM;
  logic [31:0] ALUResultM;
  logic [31:0] PCPlus4M;
  logic [31:0] CSRDataM;
  logic        RspValid;
  logic [31:0] RspData;
  logic        StallW;
  logic        FlushW;
  logic        ValidW;
  logic        RegWriteW;
  logic [4:0]  RdW;
  logic [31:0] ResultW;
  logic        WaitLoadW;
  logic        RetireW;

  int total = 0;
  int bad   = 0;

  // Behavioural model of the W slot.
  bit          m_live;   // a non-killed instruction sits in W
  bit          m_need;   // that instruction is a load still missing its data
  int          m_orph;   // responses still owed to killed loads
  bit          m_rw;
  logic [1:0]  m_src;
  logic [2:0]  m_f3;
  logic [4:0]  m_rd;
  logic [31:0] m_alu, m_pc4, m_csr, m_data;

  writeback_stage_pipe #(
    .XLEN    (32),
    .REG_AW  (5),
    .NUM_SRC (4)
  ) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .ValidM     (ValidM),
    .RegWriteM  (RegWriteM),
    .ResultSrcM (ResultSrcM),
    .LoadFuncM  (LoadFuncM),
    .RdM        (RdM),
    .ALUResultM (ALUResultM),
    .PCPlus4M   (PCPlus4M),
    .CSRDataM   (CSRDataM),
    .RspValid   (RspValid),
    .RspData    (RspData),
    .StallW     (StallW),
    .FlushW     (FlushW),
    .ValidW     (ValidW),
    .RegWriteW  (RegWriteW),
    .RdW        (RdW),
    .ResultW    (ResultW),
    .WaitLoadW  (WaitLoadW),
    .RetireW    (RetireW)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%h want=%h at %0t", name, got, want, $time);
    end
  endtask

  // Load extension computed from the RISC-V rules with shifts and masks.
  function automatic logic [31:0] model_extend(input logic [2:0] f3, input logic [31:0] addr,
                                               input logic [31:0] raw);
    logic [31:0] b, h;
    b = (raw >> (int'(addr[1:0]) * 8)) & 32'h0000_00FF;
    h = (raw >> (int'(addr[1]) * 16)) & 32'h0000_FFFF;
    case (f3)
      3'b000:  return b[7]  ? (b | 32'hFFFF_FF00) : b;
      3'b001:  return h[15] ? (h | 32'hFFFF_0000) : h;
      3'b010:  return raw;
      3'b100:  return b;
      3'b101:  return h;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] model_result();
    case (m_src)
      2'd0:    return m_alu;
      2'd1:    return model_extend(m_f3, m_alu, m_data);
      2'd2:    return m_pc4;
      default: return m_csr;
    endcase
  endfunction

  task automatic model_reset();
    m_live = 0; m_need = 0; m_orph = 0; m_rw = 0;
    m_src = '0; m_f3 = '0; m_rd = '0;
    m_alu = '0; m_pc4 = '0; m_csr = '0; m_data = '0;
  endtask

  // Compare this cycle's DUT outputs with the model, then advance the model.
  task automatic compare_cycle();
    bit          ready;
    logic [31:0] want;
    ready = m_live && !m_need;
    want  = ready ? model_result() : 32'h0;
    check("ValidW",    32'(ValidW),    32'(m_live));
    check("WaitLoadW", 32'(WaitLoadW), 32'(m_need || (m_orph > 0)));
    check("RegWriteW", 32'(RegWriteW), 32'(ready && m_rw && (m_rd != 5'd0)));
    check("ResultW",   ResultW,        want);
    check("RetireW",   32'(RetireW),   32'(ready && !StallW && !FlushW));
    if (ready && m_rw && (m_rd != 5'd0)) check("RdW", 32'(RdW), 32'(m_rd));
    // Advance to the contents after the coming clock edge.
    if (m_orph > 0) begin
      if (RspValid) m_orph--;
    end else if (m_need) begin
      if (FlushW) begin
        m_live = 0;
        m_need = 0;
        m_orph = RspValid ? 0 : 1;
      end else if (RspValid) begin
        m_data = RspData;
        m_need = 0;
      end
    end else if (!StallW) begin
      m_live = ValidM && !FlushW;
      m_rw   = RegWriteM;
      m_src  = ResultSrcM;
      m_f3   = LoadFuncM;
      m_rd   = RdM;
      m_alu  = ALUResultM;
      m_pc4  = PCPlus4M;
      m_csr  = CSRDataM;
      m_need = m_live && (ResultSrcM == 2'd1);
    end else if (FlushW) begin
      m_live = 0;
    end
  endtask

  // Compare process: inputs change on the falling edge, outputs are checked 2 units later.
  initial begin
    model_reset();
    forever begin
      @(negedge CLK or negedge RESET);
      if (!RESET) begin
        model_reset();
      end else begin
        #2;
        if (!RESET) model_reset();
        else        compare_cycle();
      end
    end
  end

  task automatic idle();
    ValidM = 0; RegWriteM = 0; ResultSrcM = 2'd0; LoadFuncM = 3'd0; RdM = 5'd0;
    ALUResultM = 32'h0; PCPlus4M = 32'h0; CSRDataM = 32'h0;
    RspValid = 0; RspData = 32'h0; StallW = 0; FlushW = 0;
  endtask

  task automatic issue_load(input logic [2:0] f3, input logic [31:0] addr, input logic [4:0] rd);
    idle();
    ValidM = 1; RegWriteM = 1; ResultSrcM = 2'd1; LoadFuncM = f3; RdM = rd; ALUResultM = addr;
    // A response in the capture cycle must be ignored.
    RspValid = 1; RspData = 32'hBAD0_BAD0;
  endtask

  // Load with its response on the third waiting cycle; checks the waits and the write.
  task automatic run_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [4:0] rd, input logic [31:0] data, input logic [31:0] want);
    @(negedge CLK); issue_load(f3, addr, rd);
    @(negedge CLK); idle(); #3 check({tag, "_wait1"}, 32'(WaitLoadW), 32'd1);
    @(negedge CLK); idle(); #3 check({tag, "_wait2"}, 32'(WaitLoadW), 32'd1);
    @(negedge CLK); idle(); RspValid = 1; RspData = data;
    #3 check({tag, "_wait3"}, 32'(WaitLoadW), 32'd1);
    check({tag, "_nowrite"}, 32'(RegWriteW), 32'd0);
    @(negedge CLK); idle();
    #3 check({tag, "_result"}, ResultW, want);
    check({tag, "_we"}, 32'(RegWriteW), 32'd1);
    check({tag, "_rd"}, 32'(RdW), 32'(rd));
    check({tag, "_done"}, 32'(WaitLoadW), 32'd0);
    check({tag, "_retire"}, 32'(RetireW), 32'd1);
  endtask

  initial begin
    logic [31:0] addr;
    RESET = 1'b0;
    idle();

    // Model pins
    check("model_lb",  model_extend(3'b000, 32'h0000_0002, 32'h0080_0000), 32'hFFFF_FF80);
    check("model_lhu", model_extend(3'b101, 32'h0000_0002, 32'hBEEF_0000), 32'h0000_BEEF);
    check("model_lh",  model_extend(3'b001, 32'h0000_0000, 32'h1234_8001), 32'hFFFF_8001);
    check("model_bad", model_extend(3'b011, 32'h0000_0000, 32'hFFFF_FFFF), 32'h0000_0000);

    // Reset state
    repeat (2) @(negedge CLK);
    #3;
    check("rst_valid", 32'(ValidW), 32'd0);
    check("rst_we",    32'(RegWriteW), 32'd0);
    check("rst_rd",    32'(RdW), 32'd0);
    check("rst_res",   ResultW, 32'h0);
    check("rst_wait",  32'(WaitLoadW), 32'd0);
    check("rst_ret",   32'(RetireW), 32'd0);
    @(negedge CLK); RESET = 1'b1;

    // ALU op
    @(negedge CLK); idle();
    ValidM = 1; RegWriteM = 1; ResultSrcM = 2'd0; RdM = 5'd5; ALUResultM = 32'h0000_1234;
    @(negedge CLK); idle();
    #3 check("alu_we", 32'(RegWriteW), 32'd1);
    check("alu_rd",  32'(RdW), 32'd5);
    check("alu_res", ResultW, 32'h0000_1234);
    check("alu_ret", 32'(RetireW), 32'd1);

    // Loads
    run_load("lb",  3'b000, 32'h0000_1002, 5'd7,  32'h0080_0000, 32'hFFFF_FF80);
    run_load("lhu", 3'b101, 32'h0000_2002, 5'd8,  32'hBEEF_0000, 32'h0000_BEEF);
    run_load("lw",  3'b010, 32'h0000_3000, 5'd9,  32'hDEAD_BEEF, 32'hDEAD_BEEF);
    run_load("lbu", 3'b100, 32'h0000_4003, 5'd10, 32'h9A00_0000, 32'h0000_009A);

    // x0 destination
    @(negedge CLK); idle();
    ValidM = 1; RegWriteM = 1; ResultSrcM = 2'd2; RdM = 5'd0; PCPlus4M = 32'h0000_0104;
    @(negedge CLK); idle();
    #3 check("x0_we",  32'(RegWriteW), 32'd0);
    check("x0_ret", 32'(RetireW), 32'd1);
    check("x0_res", ResultW, 32'h0000_0104);

    // Flush during WAIT_LD
    @(negedge CLK); issue_load(3'b010, 32'h0000_0200, 5'd11);
    @(negedge CLK); idle(); #3 check("fl_wait", 32'(WaitLoadW), 32'd1);
    @(negedge CLK); idle(); FlushW = 1; #3 check("fl_noret", 32'(RetireW), 32'd0);
    @(negedge CLK); idle();
    #3 check("drain_wait",  32'(WaitLoadW), 32'd1);
    check("drain_valid", 32'(ValidW), 32'd0);
    @(negedge CLK); idle(); RspValid = 1; RspData = 32'h1234_5678;
    #3 check("drain_we",  32'(RegWriteW), 32'd0);
    check("drain_res", ResultW, 32'h0);
    @(negedge CLK); idle();
    #3 check("drained_wait", 32'(WaitLoadW), 32'd0);
    check("drained_we",   32'(RegWriteW), 32'd0);
    check("drained_valid", 32'(ValidW), 32'd0);

    // Reset mid-WAIT_LD
    @(negedge CLK); issue_load(3'b000, 32'h0000_0001, 5'd3);
    @(negedge CLK); idle();
    #3 check("pre_rst_wait", 32'(WaitLoadW), 32'd1);
    #1 RESET = 1'b0;
    #1 check("arst_wait",  32'(WaitLoadW), 32'd0);
    check("arst_valid", 32'(ValidW), 32'd0);
    check("arst_rd",    32'(RdW), 32'd0);
    check("arst_ret",   32'(RetireW), 32'd0);
    @(negedge CLK); idle(); RESET = 1'b1;
    @(negedge CLK); idle(); RspValid = 1; RspData = 32'hFFFF_FFFF;
    #3 check("late_rsp_wait", 32'(WaitLoadW), 32'd0);
    @(negedge CLK); idle();
    #3 check("late_rsp_we",  32'(RegWriteW), 32'd0);
    check("late_rsp_res", ResultW, 32'h0);
    check("late_rsp_val", 32'(ValidW), 32'd0);

    // Randomized traffic against the model
    for (int c = 0; c < 1500; c++) begin
      @(negedge CLK);
      ValidM     = ($urandom_range(0, 3) != 0);
      RegWriteM  = 1'($urandom_range(0, 1));
      ResultSrcM = 2'($urandom_range(0, 3));
      LoadFuncM  = 3'($urandom_range(0, 7));
      RdM        = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      addr       = $urandom;
      if (ResultSrcM == 2'd1) begin
        if (LoadFuncM == 3'b010)                             addr[1:0] = 2'b00;
        else if (LoadFuncM == 3'b001 || LoadFuncM == 3'b101) addr[0]   = 1'b0;
      end
      ALUResultM = addr;
      PCPlus4M   = $urandom;
      CSRDataM   = $urandom;
      StallW     = ($urandom_range(0, 4) == 0);
      FlushW     = ($urandom_range(0, 9) == 0);
      RspValid   = ($urandom_range(0, 2) == 0);
      RspData    = $urandom;
      // Keep flush and response apart while a live load waits.
      if (m_need && (m_orph == 0) && FlushW) RspValid = 1'b0;
    end

    @(negedge CLK); idle();
    repeat (4) @(negedge CLK);
    #3;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
